// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with label-table targets,
// a small return-address stack and run/halt sequencing.
module pc_sequencer #(
  parameter int              PC_W      = 12,
  parameter logic [PC_W-1:0] START_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_en,
  input  logic            branch_cond,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic            halt_req,
  input  logic [7:0]      label_in,
  output logic [7:0]      lut_label,
  input  logic [PC_W-1:0] lut_target,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            err,
  output logic [2:0]      ras_count
);

  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];

  logic              push;
  logic [PC_W-1:0]   pc_inc;
  logic [CW-1:0]     cnt_m1;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     push_idx;
  logic              tgt_ok;
  logic              br_take;

  assign pc_inc   = pc_q + PC_W'(1);
  assign cnt_m1   = cnt_q - CW'(1);
  assign top_idx  = cnt_m1[AW-1:0];
  assign push_idx = cnt_q[AW-1:0];
  assign tgt_ok   = lut_target != '0;
  assign br_take  = branch_en && branch_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (push)
        ras_q[push_idx] <= pc_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (stall) begin
          state_d = S_RUN;
        end else if (halt_req) begin
          state_d = S_HALT;
        end else if (ret) begin
          if (cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d  = ras_q[top_idx];
            cnt_d = cnt_m1;
          end
        end else if (call) begin
          // target check first so a bad call never pushes
          if (!tgt_ok || cnt_q == CW'(RAS_DEPTH)) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            push  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            pc_d  = lut_target;
          end
        end else if (jump || br_take) begin
          if (!tgt_ok) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d = lut_target;
          end
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lut_label = label_in;
    pc        = pc_q;
    running   = state_q == S_RUN;
    done      = state_q == S_HALT;
    err       = err_q;
    ras_count = (cnt_q > CW'(7)) ? 3'd7 : cnt_q[2:0];
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random stimulus, reference model and
// scoreboard queue checked by an independent monitor.
module tb_pc_sequencer;

  localparam int         PC_W  = 12;
  localparam int         DEPTH = 4;
  localparam logic [11:0] START = 12'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 0, stall = 0, branch_en = 0, branch_cond = 0;
  logic        jump = 0, call = 0, ret = 0, halt_req = 0;
  logic [7:0]  label_in = '0;
  logic [7:0]  lut_label;
  logic [11:0] lut_target;
  logic [11:0] pc;
  logic        running, done, err;
  logic [2:0]  ras_count;

  pc_sequencer #(.PC_W(PC_W), .START_PC(START), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_cond(branch_cond), .jump(jump),
    .call(call), .ret(ret), .halt_req(halt_req), .label_in(label_in),
    .lut_label(lut_label), .lut_target(lut_target), .pc(pc),
    .running(running), .done(done), .err(err), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lut(input logic [7:0] l);
    case (l)
      8'd2:    return 12'd352;
      8'd3:    return 12'd205;
      8'd17:   return 12'd625;
      8'd200:  return 12'd4094;
      default: return 12'd0;
    endcase
  endfunction

  always_comb lut_target = lut(lut_label);

  typedef struct {
    int pc;
    int run;
    int dn;
    int er;
    int cnt;
    int lbl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: 0 idle, 1 run, 2 halt
  int m_state = 0;
  int m_pc    = 0;
  int m_err   = 0;
  int m_stk[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_stop();
    m_err   = 1;
    m_state = 2;
  endtask

  task automatic model_step(input bit st, sl, be, bc, j, c, r, h,
                            input int lb);
    int t;
    t = int'(lut(8'(lb)));
    if (m_state != 1) begin
      if (st) begin
        m_state = 1;
        m_pc    = int'(START);
        m_err   = 0;
        m_stk.delete();
      end
    end else if (sl) begin
      m_state = 1;
    end else if (h) begin
      m_state = 2;
    end else if (r) begin
      if (m_stk.size() == 0) fail_stop();
      else m_pc = m_stk.pop_back();
    end else if (c) begin
      if (t == 0 || m_stk.size() == DEPTH) fail_stop();
      else begin
        m_stk.push_back((m_pc + 1) % 4096);
        m_pc = t;
      end
    end else if (j || (be && bc)) begin
      if (t == 0) fail_stop();
      else m_pc = t;
    end else begin
      m_pc = (m_pc + 1) % 4096;
    end
  endtask

  task automatic cyc(input bit st, sl, be, bc, j, c, r, h, input int lb);
    exp_t e;
    @(negedge clk);
    start = st; stall = sl; branch_en = be; branch_cond = bc;
    jump = j; call = c; ret = r; halt_req = h; label_in = 8'(lb);
    model_step(st, sl, be, bc, j, c, r, h, lb);
    e.pc  = m_pc;
    e.run = (m_state == 1) ? 1 : 0;
    e.dn  = (m_state == 2) ? 1 : 0;
    e.er  = m_err;
    e.cnt = m_stk.size();
    e.lbl = lb;
    exp_q.push_back(e);
  endtask

  task automatic plain(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_inputs();
    start = 0; stall = 0; branch_en = 0; branch_cond = 0;
    jump = 0; call = 0; ret = 0; halt_req = 0; label_in = '0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_pc"}, 32'(pc), 32'(START));
    chk({tag, "_running"}, 32'(running), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ras_count"}, 32'(ras_count), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", 32'(pc), 32'(e.pc));
        chk("running", 32'(running), 32'(e.run));
        chk("done", 32'(done), 32'(e.dn));
        chk("err", 32'(err), 32'(e.er));
        chk("ras_count", 32'(ras_count), 32'(e.cnt));
        chk("lut_label", 32'(lut_label), 32'(e.lbl));
      end
    end
  end

  initial begin : driver
    int lbls[6];
    lbls = '{2, 3, 17, 99, 200, 5};
    #3 rst_n = 1'b0;
    #1 reset_check("por");
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    plain(5);
    plain(2);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 17);

    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    plain(10);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 1) cyc(0, 0, 0, 0, 0, 1, 0, 0, 3);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 1, 0, 0, 1, 17);
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 17);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 99);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 200);
    plain(2);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 3);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_check("mid_run");
    m_state = 0; m_pc = int'(START); m_err = 0; m_stk.delete();
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3000) begin
      cyc($urandom_range(15) == 0, $urandom_range(7) == 0,
          $urandom_range(2) == 0, $urandom_range(1) == 1,
          $urandom_range(7) == 0, $urandom_range(5) == 0,
          $urandom_range(5) == 0, $urandom_range(31) == 0,
          lbls[$urandom_range(5)]);
    end

    @(negedge clk);
    zero_inputs();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
